// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with TX FIFO and status register
module uart_tx_mmio #(
  parameter int          CLKS_PER_BIT = 104,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        memwrite,
  input  logic        memread,
  output logic [31:0] read_data,
  output logic        tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ovf_q, ovf_d, tx_q, tx_d;
  logic          wr_txd, rd_txd, rd_st, full, empty, pop, push, baud_end;
  logic          unused;
  assign unused   = ^write_data[31:8];
  assign wr_txd   = memwrite && addr == BASE_ADDR;
  assign rd_txd   = memread && addr == BASE_ADDR;
  assign rd_st    = memread && addr == BASE_ADDR + 32'd4;
  assign full     = cnt_q == 5'(FIFO_DEPTH);
  assign empty    = cnt_q == '0;
  assign baud_end = baud_q == CW'(CLKS_PER_BIT - 1);
  // a full FIFO still accepts a push when the transmitter frees a slot in the same cycle
  assign push     = wr_txd && (!full || pop);
  always_comb begin
    state_d = state_q;
    baud_d  = baud_end ? '0 : baud_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: if (baud_end) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (baud_end) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      default: if (baud_end) begin
        pop     = !empty;
        state_d = empty ? IDLE : START;
      end
    endcase
    if (pop) shift_d = mem_q[rptr_q];
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    cnt_d   = cnt_q + 5'(push) - 5'(pop);
    ovf_d   = (wr_txd && !push) ? 1'b1 : rd_st ? 1'b0 : ovf_q;
    rdata_d = rd_st ? {23'd0, cnt_q, ovf_q, state_q != IDLE, empty, full} : rd_txd ? '0 : rdata_q;
    // drive the line from the next state so tx is a clean flop output
    tx_d    = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rdata_q <= '0;
      ovf_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rdata_q <= rdata_d;
      ovf_q   <= ovf_d;
      tx_q    <= tx_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= write_data[7:0];
  end
  assign read_data = rdata_q;
  assign tx        = tx_q;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: randomized and directed bench against a frame-timing reference model
module tb_uart_tx_mmio;
  localparam int          CPB  = 4;
  localparam int          DEP  = 8;
  localparam logic [31:0] BASE = 32'h0000_2000;
  logic        clk, reset, memwrite, memread, tx;
  logic [31:0] addr, write_data, read_data;
  logic [7:0]  q[$];
  logic [7:0]  cur;
  logic [31:0] m_rd;
  logic        m_ovf, m_tx;
  int          rem, cmp, bad;

  uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .addr(addr), .write_data(write_data),
    .memwrite(memwrite), .memread(memread), .read_data(read_data), .tx(tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  function automatic logic frame_bit(logic [7:0] b, int i);
    return i == 0 ? 1'b0 : i == 9 ? 1'b1 : b[i-1];
  endfunction

  // rem = cycles of the current frame still to be shown on the line after this edge
  task automatic model_edge();
    logic p, ovs;
    logic [31:0] st;
    if (!reset) begin
      p   = q.size() > 0 && rem <= 1;
      st  = {23'd0, 5'(q.size()), m_ovf, rem > 0, q.size() == 0, q.size() == DEP};
      ovs = 1'b0;
      if (rem > 0) rem--;
      if (p) begin
        cur = q.pop_front();
        rem = 10 * CPB;
      end
      if (memwrite && addr == BASE) begin
        if (q.size() < DEP) q.push_back(write_data[7:0]);
        else ovs = 1'b1;
      end
      if (ovs) m_ovf = 1'b1;
      else if (memread && addr == BASE + 4) m_ovf = 1'b0;
      if (memread && addr == BASE + 4) m_rd = st;
      else if (memread && addr == BASE) m_rd = '0;
      m_tx = rem == 0 ? 1'b1 : frame_bit(cur, (10 * CPB - rem) / CPB);
    end
  endtask

  task automatic model_clear();
    q.delete();
    rem = 0; m_ovf = 1'b0; m_rd = '0; m_tx = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    memwrite = 1'b0; memread = 1'b0;
    addr = $urandom; write_data = $urandom;
  endtask

  task automatic wr(input logic [7:0] b);
    addr = BASE; write_data = {24'($urandom), b}; memwrite = 1'b1;
    tick();
  endtask

  task automatic rd(input logic [31:0] a);
    addr = a; memread = 1'b1;
    tick();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    cmp++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b expected 1", tx); end
    cmp++; if (read_data !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h expected 0", read_data); end
    rd(BASE + 4);
    cmp++; if (read_data !== 32'h2) begin bad++; $display("FAIL reset_status: got %h expected 00000002", read_data); end
  endtask

  task automatic test_single();
    logic [9:0] seq = 10'b1101001010;
    wr(8'hA5);
    cmp++; if (tx !== 1'b1) begin bad++; $display("FAIL single_latency: got %b expected 1", tx); end
    for (int c = 0; c < 40; c++) begin
      tick();
      cmp++;
      if (tx !== seq[c / CPB] || tx !== m_tx) begin
        bad++; $display("FAIL single_bit c=%0d: got %b expected %b", c, tx, seq[c / CPB]);
      end
    end
    tick();
    rd(BASE + 4);
    cmp++; if (read_data !== 32'h2) begin bad++; $display("FAIL single_status: got %h expected 00000002", read_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[3] = '{8'h01, 8'h02, 8'h03};
    wr(b[0]);
    cmp++; if (tx !== 1'b1) begin bad++; $display("FAIL b2b_latency: got %b expected 1", tx); end
    wr(b[1]);
    wr(b[2]);
    for (int c = 2; c < 120; c++) begin
      tick();
      cmp++;
      if (tx !== frame_bit(b[c / 40], (c % 40) / CPB)) begin
        bad++; $display("FAIL b2b_bit c=%0d: got %b expected %b", c, tx, frame_bit(b[c / 40], (c % 40) / CPB));
      end
    end
    tick();
    cmp++; if (tx !== 1'b1) begin bad++; $display("FAIL b2b_end_idle: got %b expected 1", tx); end
    rd(BASE + 4);
    cmp++; if (read_data !== 32'h2) begin bad++; $display("FAIL b2b_status: got %h expected 00000002", read_data); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 10; i++) wr(8'($urandom));
    rd(BASE + 4);
    cmp++; if (read_data !== 32'h8D || read_data !== m_rd) begin bad++; $display("FAIL ovf_status: got %h expected 0000008d", read_data); end
    rd(BASE + 4);
    cmp++; if (read_data !== 32'h85 || read_data !== m_rd) begin bad++; $display("FAIL ovf_cleared: got %h expected 00000085", read_data); end
    repeat (9 * 40 + 5) begin
      tick();
      cmp++; if (tx !== m_tx) begin bad++; $display("FAIL ovf_drain_tx: got %b expected %b", tx, m_tx); end
    end
    rd(BASE + 4);
    cmp++; if (read_data !== 32'h2) begin bad++; $display("FAIL ovf_drain_status: got %h expected 00000002", read_data); end
  endtask

  task automatic test_full_push_pop();
    int n = 0;
    for (int i = 0; i < 9; i++) wr(8'($urandom));
    while (!(rem == 1 && q.size() == DEP) && n < 100) begin
      tick();
      n++;
    end
    cmp++; if (n >= 100) begin bad++; $display("FAIL fpp_wait: got timeout expected pop window"); end
    wr(8'($urandom));
    rd(BASE + 4);
    cmp++; if (read_data !== 32'h85 || read_data !== m_rd) begin bad++; $display("FAIL fpp_status: got %h expected 00000085", read_data); end
    repeat (9 * 40 + 5) begin
      tick();
      cmp++; if (tx !== m_tx) begin bad++; $display("FAIL fpp_drain_tx: got %b expected %b", tx, m_tx); end
    end
  endtask

  task automatic test_reset_mid();
    wr(8'($urandom) & 8'hF7);
    repeat (18) tick();
    cmp++; if (tx !== 1'b0) begin bad++; $display("FAIL mid_bit3: got %b expected 0", tx); end
    #2 reset = 1'b1;
    model_clear();
    #1;
    cmp++; if (tx !== 1'b1) begin bad++; $display("FAIL mid_reset_tx: got %b expected 1", tx); end
    @(posedge clk);
    #1 reset = 1'b0;
    rd(BASE + 4);
    cmp++; if (read_data !== 32'h2) begin bad++; $display("FAIL mid_status: got %h expected 00000002", read_data); end
    repeat (60) begin
      tick();
      cmp++; if (tx !== 1'b1) begin bad++; $display("FAIL mid_quiet: got %b expected 1", tx); end
    end
  endtask

  task automatic test_random();
    repeat (1500) begin
      int r = $urandom_range(0, 19);
      addr = r < 2 ? BASE : r < 5 ? BASE + 4 : r < 7 ? BASE : r < 8 ? BASE + 8 : $urandom;
      memwrite = r < 2 || r == 5 || r == 8;
      memread  = (r >= 2 && r < 8) && r != 5;
      write_data = $urandom;
      tick();
      cmp++; if (tx !== m_tx) begin bad++; $display("FAIL rand_tx: got %b expected %b", tx, m_tx); end
      cmp++; if (read_data !== m_rd) begin bad++; $display("FAIL rand_rdata: got %h expected %h", read_data, m_rd); end
    end
    repeat (9 * 40 + 5) begin
      tick();
      cmp++; if (tx !== m_tx) begin bad++; $display("FAIL rand_drain_tx: got %b expected %b", tx, m_tx); end
    end
    rd(BASE + 4);
    cmp++; if (read_data !== m_rd) begin bad++; $display("FAIL rand_status: got %h expected %h", read_data, m_rd); end
  endtask

  initial begin
    cmp = 0; bad = 0;
    reset = 1'b1; memwrite = 1'b0; memread = 1'b0; addr = '0; write_data = '0;
    model_clear();
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the processor's data-memory bus, alongside the data memory that drives the LEDs. Software writes bytes to a TX data register; bytes are queued in a small FIFO and serialised 8N1, LSB first, on a single output line. A status register reports FIFO level, line activity and a sticky overflow flag.

## Interface
- CLKS_PER_BIT, 104, clock cycles per serial bit; legal range ≥ 2.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2–16.
- BASE_ADDR, 32'h0000_2000, byte address of TXDATA; STATUS is at BASE_ADDR+4.

- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  32  data-bus byte address.
- write_data  input  32  data-bus write data; only bits [7:0] are used.
- memwrite  input  1  write strobe, one cycle per access.
- memread  input  1  read strobe, one cycle per access.
- read_data  output  32  registered read data.
- tx  output  1  serial line; idle high.

## Operation
- Address decode is a full 32-bit compare. Accesses to other addresses are ignored. Writes to STATUS and reads of TXDATA have no effect; those reads return 0.
- TXDATA write pushes write_data[7:0] into the FIFO.
- A push while the FIFO is full is dropped and sets `overflow`. The one exception: if the transmitter pops in the same cycle, the push is accepted and the count is unchanged.
- STATUS read data is 32 bits:
  - bit0 = full.
  - bit1 = empty.
  - bit2 = tx_active (state ≠ IDLE).
  - bit3 = overflow.
  - bits[8:4] = FIFO count (0..FIFO_DEPTH).
  - all other bits 0.
- Reading STATUS clears `overflow` at the same edge. If an overflowing push happens in that same cycle, the set wins.
- FIFO: circular buffer with log2(FIFO_DEPTH)-bit read/write pointers that wrap modulo FIFO_DEPTH, plus a separate count register.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, clear the baud counter and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After bit index 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. Bit index is 3 bits.
- tx is a registered output, free of glitches.

## Timing
- Reset values:
  - tx=1, read_data=0.
  - FIFO empty (count 0, pointers 0), overflow=0.
  - state IDLE, counters 0.
- Reset asserted mid-frame forces tx high immediately. The in-flight byte and the FIFO contents are discarded.
- Read latency: read_data is valid at the edge after the cycle memread is sampled. It holds that value until the next decoded read or reset. It is not cleared on non-read cycles.
- Write to an empty, idle block at edge k: count=1 after edge k. The pop and the START transition happen at edge k+1, so tx falls after edge k+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles. Back-to-back frames run with no gap.
- Pop happens only in the IDLE→START or STOP→START transition, one entry per frame.
- STATUS reflects the state before the edge of the read cycle. A push and a read in the same cycle therefore report the pre-push count.

## Test plan
- Reset state: assert reset → tx=1, and STATUS read returns 32'h0000_0002 (empty).
- Single byte, CLKS_PER_BIT=4: write 8'hA5 to TXDATA.
  - tx falls one cycle later.
  - Sampled bits are 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each held 4 cycles.
  - STATUS returns to 32'h2 after 40 cycles.
- Back-to-back: write 8'h01, 8'h02, 8'h03 in consecutive cycles → three frames with no idle cycle between stop and the next start; total 120 cycles.
- Full/overflow, FIFO_DEPTH=8:
  - Write 10 bytes in 10 consecutive cycles. The first is popped one cycle after its write; the FIFO fills with bytes 2–9 and byte 10 is dropped.
  - STATUS = full, overflow, count 8.
  - A second STATUS read shows overflow=0.
- Simultaneous full push and pop: FIFO full, write timed to coincide with the STOP→START pop → byte accepted, count stays 8, overflow stays 0.
- Reset mid-frame: assert reset during DATA bit 3 → tx=1 within the same cycle. After release, STATUS=32'h2 and no further frame is emitted.
